bar_param_scheduler: RTL
========================

Name: bar_param_scheduler

Overview:
- Sequences the random bar-pattern parameters that drive the thick-bar video generator.
- Counts tempo pulses. When an update is due, it waits for the start of vertical blanking. It then loads NUM_SLOTS bar slots (slope, offset, half-width) from the LFSR one slot per cycle into shadow registers. Finally it commits all slots plus the foreground/background colours atomically.
- Sits between the LFSR/tempo blocks and the pixel colour logic. The pattern changes only between frames, so there is no tearing.

Parameters:
- NUM_SLOTS, 4, number of bar slots (1..8).
- V_PIXEL_MAX, 960, first non-visible line; vblank start is v_count == V_PIXEL_MAX with h_count == 0.
- BEATS_PER_UPDATE, 1, tempo pulses per parameter update (1..15).
- WIDTH_MIN, 8, floor applied to loaded half-widths.

Ports:
- clk_in  in  1  system/pixel clock
- reset  in  1  synchronous, active-high reset
- half_sec_pulse  in  1  one-cycle tempo pulse
- h_count  in  12  current pixel column from vga_sync
- v_count  in  12  current line from vga_sync
- rnd_a  in  13  LFSR word; sampled every LOAD/COMMIT cycle
- rnd_b  in  13  second LFSR word; sampled every LOAD/COMMIT cycle
- slope_bus  out  4*NUM_SLOTS  active slope per slot; slot k at [4k+3:4k]
- offset_bus  out  4*NUM_SLOTS  active offset per slot
- width_bus  out  8*NUM_SLOTS  active half-width per slot
- fg_rgb  out  12  active bar colour {r,g,b}
- bg_rgb  out  12  active background colour {r,g,b}
- busy  out  1  high in ARMED, LOAD, COMMIT
- update_done  out  1  one-cycle pulse when new parameters become active

Behaviour:
- Reset (synchronous):
  - State IDLE; beat counter 0; pending 0; busy 0; update_done 0.
  - Slot k active and shadow values: slope k+1, offset 0, width 32.
  - fg_rgb 12'hF00; bg_rgb 12'h000.
  - Reset mid-operation discards the shadow contents and the pending flag.
- Beat counter:
  - Increments on each half_sec_pulse, in any state.
  - On the pulse that brings it to BEATS_PER_UPDATE it clears to 0 and raises an update request.
  - If the request occurs in IDLE, go to ARMED the next cycle.
  - Otherwise set pending. Multiple requests coalesce into one pending update.
- vblank_start is the single cycle with v_count == V_PIXEL_MAX && h_count == 0.
- IDLE:
  - If pending, clear pending and go to ARMED.
  - Else wait.
- ARMED:
  - Wait for vblank_start.
  - On the cycle where vblank_start is high: slot index = 0, go to LOAD.
  - A request and vblank_start in the same IDLE cycle still goes only to ARMED, so this update waits for the next frame.
- LOAD (NUM_SLOTS cycles; slot index i = 0..NUM_SLOTS-1). Each cycle writes shadow slot i:
  - slope = rnd_a[3:0], with 0 replaced by 1.
  - offset = rnd_a[7:4].
  - width = rnd_b[7:0] if >= WIDTH_MIN, else WIDTH_MIN.
  - Increment i. After slot NUM_SLOTS-1, go to COMMIT.
- COMMIT (one cycle):
  - At the closing edge: all active slot registers <= shadow; fg_rgb <= rnd_a[11:0]; bg_rgb <= rnd_b[11:0].
  - Also at that edge: update_done <= 1 for exactly one cycle, and the state goes to IDLE.
- Latency:
  - vblank_start seen in cycle T.
  - Slots are written at the edges ending T+1 .. T+NUM_SLOTS.
  - New outputs and update_done are visible in cycle T+NUM_SLOTS+2.
  - All of this falls well inside vblank.
- Outputs change only at the COMMIT edge or at reset; they are never partially updated.
- busy = (state != IDLE), registered with the state.
- A tempo pulse during LOAD/COMMIT that completes a beat count sets pending. Exactly one further update then occurs, starting at the next frame's vblank_start.

Test Plan:
- Reset values: assert reset 3 cycles -> slope_bus = {4,3,2,1}, offset_bus = 0, every width = 32, fg_rgb = F00, bg_rgb = 000, busy = 0, update_done = 0.
- Basic update (BEATS_PER_UPDATE=1): pulse at v_count=100 -> busy=1, outputs unchanged until vblank_start at T; update_done high exactly at T+6. Drive rnd_a=13'h0125, rnd_b=13'h0040 constant -> every slot slope=5, offset=2, width=64, fg=125, bg=040.
- Clamping: rnd_a[3:0]=0, rnd_b[7:0]=3 -> all slopes=1, all widths=8.
- Beat division (BEATS_PER_UPDATE=3): 2 pulses -> no ARMED. 3rd pulse -> one update at the next vblank.
- Coalesced pending: 3 pulses during LOAD -> exactly one extra update, occurring at the following frame's vblank_start. Total update_done count = 2.
- Reset mid-LOAD: assert reset at T+2 -> reset values restored, no update_done, busy=0. The next pulse produces a normal update.

Source files
------------

// File: rtl/bar_param_scheduler.sv
// bar_param_scheduler
// Picks new random bar-pattern parameters for the thick-bar video generator.
// The parameters change only during vertical blanking, so a frame never shows a half-updated
// pattern.
//
// Operation:
//   - Tempo pulses are counted.
//   - When an update is due, the block waits for the start of vblank.
//   - It then fills one shadow slot per cycle from the LFSR words.
//   - Finally it commits all slots and both colours in a single edge.
//
// Ports:
//   clk_in          system/pixel clock
//   reset           synchronous, active-high reset
//   half_sec_pulse  one-cycle tempo pulse
//   h_count/v_count raster position from vga_sync (12 bits each)
//   rnd_a/rnd_b     LFSR words (13 bits), sampled in LOAD and COMMIT cycles
//   slope_bus       active slope per slot, slot k at [4k+3:4k]
//   offset_bus      active offset per slot, slot k at [4k+3:4k]
//   width_bus       active half-width per slot, slot k at [8k+7:8k]
//   fg_rgb/bg_rgb   active bar/background colour {r,g,b}
//   busy            high while an update is armed, loading or committing
//   update_done     one-cycle pulse in the first cycle the new parameters are active
module bar_param_scheduler #(
    parameter int unsigned NUM_SLOTS        = 4,
    parameter int unsigned V_PIXEL_MAX      = 960,
    parameter int unsigned BEATS_PER_UPDATE = 1,
    parameter int unsigned WIDTH_MIN        = 8
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     half_sec_pulse,
    input  logic [11:0]              h_count,
    input  logic [11:0]              v_count,
    input  logic [12:0]              rnd_a,
    input  logic [12:0]              rnd_b,
    output logic [4*NUM_SLOTS-1:0]   slope_bus,
    output logic [4*NUM_SLOTS-1:0]   offset_bus,
    output logic [8*NUM_SLOTS-1:0]   width_bus,
    output logic [11:0]              fg_rgb,
    output logic [11:0]              bg_rgb,
    output logic                     busy,
    output logic                     update_done
);

    localparam int unsigned    IdxW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_SLOTS - 1);
    localparam logic [3:0]     BeatLast   = 4'(BEATS_PER_UPDATE - 1);
    localparam logic [11:0]    VblankLine = 12'(V_PIXEL_MAX);
    localparam logic [7:0]     WidthMin   = 8'(WIDTH_MIN);

    typedef enum logic [1:0] {StIdle, StArmed, StLoad, StCommit} state_e;

    state_e          state_q;
    logic [3:0]      beat_q;
    logic            pending_q;
    logic [IdxW-1:0] idx_q;

    logic [3:0] slope_q     [NUM_SLOTS];
    logic [3:0] offset_q    [NUM_SLOTS];
    logic [7:0] width_q     [NUM_SLOTS];
    logic [3:0] slope_sh_q  [NUM_SLOTS];
    logic [3:0] offset_sh_q [NUM_SLOTS];
    logic [7:0] width_sh_q  [NUM_SLOTS];

    logic       vblank_start;
    logic       beat_hit;
    logic [3:0] slope_new;
    logic [7:0] width_new;
    logic       unused_rnd;

    assign vblank_start = (v_count == VblankLine) && (h_count == 12'd0);
    assign beat_hit     = half_sec_pulse && (beat_q == BeatLast);
    // A zero slope would draw a degenerate bar, so it is bumped to 1.
    assign slope_new    = (rnd_a[3:0] == 4'd0) ? 4'd1 : rnd_a[3:0];
    assign width_new    = (rnd_b[7:0] < WidthMin) ? WidthMin : rnd_b[7:0];
    assign unused_rnd   = rnd_a[12] ^ rnd_b[12];

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= StIdle;
            beat_q      <= 4'd0;
            pending_q   <= 1'b0;
            idx_q       <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
            fg_rgb      <= 12'hF00;
            bg_rgb      <= 12'h000;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slope_q[k]     <= 4'(k + 1);
                offset_q[k]    <= 4'd0;
                width_q[k]     <= 8'd32;
                slope_sh_q[k]  <= 4'(k + 1);
                offset_sh_q[k] <= 4'd0;
                width_sh_q[k]  <= 8'd32;
            end
        end else begin
            update_done <= 1'b0;

            if (half_sec_pulse) begin
                beat_q <= beat_hit ? 4'd0 : beat_q + 4'd1;
            end

            unique case (state_q)
                StIdle: begin
                    // A fresh request or a leftover pending one both arm; they coalesce.
                    if (beat_hit || pending_q) begin
                        state_q   <= StArmed;
                        busy      <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                StArmed: begin
                    if (vblank_start) begin
                        idx_q   <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    slope_sh_q[idx_q]  <= slope_new;
                    offset_sh_q[idx_q] <= rnd_a[7:4];
                    width_sh_q[idx_q]  <= width_new;
                    if (idx_q == IdxLast) begin
                        state_q <= StCommit;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StCommit: begin
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        slope_q[k]  <= slope_sh_q[k];
                        offset_q[k] <= offset_sh_q[k];
                        width_q[k]  <= width_sh_q[k];
                    end
                    fg_rgb      <= rnd_a[11:0];
                    bg_rgb      <= rnd_b[11:0];
                    update_done <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            // Requests arriving while an update is in flight are remembered once.
            if (beat_hit && (state_q != StIdle)) begin
                pending_q <= 1'b1;
            end
        end
    end

    always_comb begin
        slope_bus  = '0;
        offset_bus = '0;
        width_bus  = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slope_bus[4*k +: 4]  = slope_q[k];
            offset_bus[4*k +: 4] = offset_q[k];
            width_bus[8*k +: 8]  = width_q[k];
        end
    end

endmodule
